cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer for a small 8-bit CPU: reset-vector load, opcode fetch,
// operand fetch for IMP/IMM/ZP/ABS modes, memory access and execute strobes.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  data,
  input  logic [15:0] pc,
  input  logic [2:0]  addr_mode,
  input  logic        is_store,
  output logic [15:0] addr,
  output logic        pc_load,
  output logic [15:0] pc_load_val,
  output logic        pc_inc,
  output logic [7:0]  ir,
  output logic [7:0]  operand,
  output logic        reg_wr_en,
  output logic        mem_we,
  output logic        sync,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  localparam logic [2:0] MODE_IMP = 3'd0;
  localparam logic [2:0] MODE_IMM = 3'd1;
  localparam logic [2:0] MODE_ZP  = 3'd2;
  localparam logic [2:0] MODE_ABS = 3'd3;

  localparam logic [AW-1:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [AW-1:0] VEC_HI_ADDR = 16'hFFFD;
  localparam logic [DW-1:0] IR_RESET    = 8'hEA;

  typedef enum logic [2:0] {
    VEC_LO = 3'd0,
    VEC_HI = 3'd1,
    FETCH  = 3'd2,
    OP_LO  = 3'd3,
    OP_HI  = 3'd4,
    MEM    = 3'd5,
    EXEC   = 3'd6
  } state_t;

  state_t        st;
  logic [DW-1:0] vec_lo;
  logic [DW-1:0] opnd_lo;
  logic [DW-1:0] opnd_hi;
  logic          go;

  assign state = st;

  // Strobes only fire when memory is ready and reset is not pending.
  assign go = rdy & ~rst;

  // Address and strobe decode; encoding 7 falls into the VEC_LO default.
  always_comb begin
    addr        = pc;
    sync        = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    reg_wr_en   = 1'b0;
    mem_we      = 1'b0;
    illegal     = 1'b0;
    pc_load_val = {data, vec_lo};
    case (st)
      VEC_HI: begin
        addr    = VEC_HI_ADDR;
        pc_load = go;
      end
      FETCH: begin
        sync   = 1'b1;
        pc_inc = go;
      end
      OP_LO: begin
        if (addr_mode[2]) begin
          illegal = go;
        end else if (addr_mode != MODE_IMP) begin
          pc_inc = go;
        end
      end
      OP_HI: begin
        pc_inc = go;
      end
      MEM: begin
        addr   = (addr_mode == MODE_ZP) ? {8'h00, opnd_lo} : {opnd_hi, opnd_lo};
        mem_we = go & is_store;
      end
      EXEC: begin
        reg_wr_en = go;
      end
      default: begin
        addr = VEC_LO_ADDR;
      end
    endcase
  end

  // State and datapath registers; everything holds while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= VEC_LO;
      ir      <= IR_RESET;
      operand <= '0;
      vec_lo  <= '0;
      opnd_lo <= '0;
      opnd_hi <= '0;
    end else if (rdy) begin
      case (st)
        VEC_HI: st <= FETCH;
        FETCH: begin
          ir <= data;
          st <= OP_LO;
        end
        OP_LO: begin
          case (addr_mode)
            MODE_IMM: begin
              operand <= data;
              opnd_lo <= data;
              st      <= EXEC;
            end
            MODE_ZP: begin
              operand <= data;
              opnd_lo <= data;
              st      <= MEM;
            end
            MODE_ABS: begin
              operand <= data;
              opnd_lo <= data;
              st      <= OP_HI;
            end
            default: st <= EXEC;
          endcase
        end
        OP_HI: begin
          opnd_hi <= data;
          st      <= MEM;
        end
        MEM: begin
          if (is_store) begin
            st <= FETCH;
          end else begin
            operand <= data;
            st      <= EXEC;
          end
        end
        EXEC: st <= FETCH;
        default: begin
          vec_lo <= data;
          st     <= VEC_HI;
        end
      endcase
    end
  end

endmodule
